// File: rtl/regfile_mover_pkg.sv
// Shared definitions for the memory <-> register-file block mover:
// operation modes, sequencer states and default widths.
package regfile_mover_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_MEM_AW = 7;
  localparam int DEFAULT_REG_AW = 5;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'b00,
    MODE_LOAD    = 2'b01,
    MODE_STORE   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_LOAD_TAIL,
    S_STORE,
    S_DONE
  } state_e;

endpackage

// File: rtl/xfer_counter.sv
// Up-counter with synchronous clear and enable; tc_o flags the all-ones
// terminal count so the sequencer can stop without relying on wrap-around.
module xfer_counter #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == '1);

endmodule

// File: rtl/regfile_block_mover.sv
// Sequencer that fills memory with a descending pattern, or moves one
// register-file-sized block between memory and the register file.
module regfile_block_mover
  import regfile_mover_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int MEM_AW = DEFAULT_MEM_AW,
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic [MEM_AW-REG_AW-1:0] blk_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [MEM_AW-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic                     mem_we_o,
  output logic                     mem_re_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic [REG_AW-1:0]        rf_wsel_o,
  output logic [DATA_W-1:0]        rf_wdata_o,
  output logic                     rf_we_o,
  output logic [REG_AW-1:0]        rf_rsel_o,
  input  logic [DATA_W-1:0]        rf_rdata_i
);

  state_e                     state_q, state_d;
  logic [MEM_AW-REG_AW-1:0]   blk_q, blk_d;
  logic                       err_q, err_d;
  logic                       rfWePend_q, rfWePend_d;
  logic [REG_AW-1:0]          rfWsel_q, rfWsel_d;

  logic [MEM_AW-1:0] memCount;
  logic              memTc;
  logic [REG_AW-1:0] regCount;
  logic              regTc;
  logic              counterClear;
  logic              memEn;
  logic              regEn;
  logic [MEM_AW-1:0] fillPattern;

  assign counterClear = (state_q == S_IDLE);
  assign memEn        = (state_q == S_FILL);
  assign regEn        = (state_q == S_LOAD) || (state_q == S_STORE);

  xfer_counter #(.W(MEM_AW)) u_memCounter (
    .clock   (clock),
    .reset   (reset),
    .clear_i (counterClear),
    .en_i    (memEn),
    .count_o (memCount),
    .tc_o    (memTc)
  );

  xfer_counter #(.W(REG_AW)) u_regCounter (
    .clock   (clock),
    .reset   (reset),
    .clear_i (counterClear),
    .en_i    (regEn),
    .count_o (regCount),
    .tc_o    (regTc)
  );

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    err_d      = 1'b0;
    rfWePend_d = 1'b0;
    rfWsel_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          blk_d = blk_i;
          case (mode_i)
            MODE_FILL:  state_d = S_FILL;
            MODE_LOAD:  state_d = S_LOAD;
            MODE_STORE: state_d = S_STORE;
            default:    err_d   = 1'b1;
          endcase
        end
      end
      S_FILL: begin
        if (memTc) state_d = S_DONE;
      end
      // Read data arrives a cycle late, so the register write for index i
      // is scheduled one cycle after its memory read is issued.
      S_LOAD: begin
        rfWePend_d = 1'b1;
        rfWsel_d   = regCount;
        if (regTc) state_d = S_LOAD_TAIL;
      end
      S_LOAD_TAIL: state_d = S_DONE;
      S_STORE: begin
        if (regTc) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      err_q      <= 1'b0;
      rfWePend_q <= 1'b0;
      rfWsel_q   <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      err_q      <= err_d;
      rfWePend_q <= rfWePend_d;
      rfWsel_q   <= rfWsel_d;
    end
  end

  assign fillPattern = ~memCount;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rf_rsel_o   = '0;
    case (state_q)
      S_FILL: begin
        mem_addr_o  = memCount;
        mem_wdata_o = DATA_W'(fillPattern);
      end
      S_LOAD: mem_addr_o = {blk_q, regCount};
      S_STORE: begin
        mem_addr_o  = {blk_q, regCount};
        rf_rsel_o   = regCount;
        mem_wdata_o = rf_rdata_i;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = err_q;
  assign mem_we_o   = (state_q == S_FILL) || (state_q == S_STORE);
  assign mem_re_o   = (state_q == S_LOAD);
  assign rf_we_o    = rfWePend_q;
  assign rf_wsel_o  = rfWsel_q;
  assign rf_wdata_o = rfWePend_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_regfile_block_mover.sv
// Directed bench for regfile_block_mover with behavioural memory (1-cycle
// read latency) and register file (combinational read) models.
module tb_regfile_block_mover;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [1:0]  blk;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  memAddr;
  logic [31:0] memWdata;
  logic        memWe;
  logic        memRe;
  logic [31:0] memRdata;
  logic [4:0]  rfWsel;
  logic [31:0] rfWdata;
  logic        rfWe;
  logic [4:0]  rfRsel;
  logic [31:0] rfRdata;

  logic        tbRfWe;
  logic [4:0]  tbRfSel;
  logic [31:0] tbRfData;

  logic [31:0] memArray [0:127];
  logic [31:0] rfArray  [0:31];

  int vectorCount;
  int miscompareCount;

  int doneCount, doneCycle, doneCycle2;
  int busyCount, busyLowCount;
  int memWeCount, memWeFirst, memWeLast;
  int memReCount, memReFirst;
  int rfWeCount, rfWeFirst, rfWeLast;
  int errCount, errCycle;
  int overlapCount, addrViolCount, postResetCount;
  int badCount;

  regfile_block_mover dut (
    .clock       (clock),
    .reset       (reset),
    .start_i     (start),
    .mode_i      (mode),
    .blk_i       (blk),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_we_o    (memWe),
    .mem_re_o    (memRe),
    .mem_rdata_i (memRdata),
    .rf_wsel_o   (rfWsel),
    .rf_wdata_o  (rfWdata),
    .rf_we_o     (rfWe),
    .rf_rsel_o   (rfRsel),
    .rf_rdata_i  (rfRdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (memWe) memArray[memAddr] <= memWdata;
    if (memRe) memRdata <= memArray[memAddr];
  end

  always @(posedge clock) begin
    if (rfWe) rfArray[rfWsel] <= rfWdata;
    else if (tbRfWe) rfArray[tbRfSel] <= tbRfData;
  end

  assign rfRdata = rfArray[rfRsel];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      miscompareCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Accept one start at edge 0, then sample cycles 1..limit and tally strobes.
  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] b, input int limit,
                               input int repulseAt, input int resetAt, input bit holdStart);
    doneCount = 0; doneCycle = 0; doneCycle2 = 0; busyCount = 0; busyLowCount = 0;
    memWeCount = 0; memWeFirst = 0; memWeLast = 0; memReCount = 0; memReFirst = 0;
    rfWeCount = 0; rfWeFirst = 0; rfWeLast = 0; errCount = 0; errCycle = 0;
    overlapCount = 0; addrViolCount = 0; postResetCount = 0;
    mode = m; blk = b; start = 1'b1;
    @(posedge clock); #1;
    if (!holdStart) start = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (!holdStart) start = (k == repulseAt);
      reset = (k == resetAt);
      if (busy) busyCount++; else busyLowCount++;
      if (done) begin
        doneCount++;
        if (doneCount == 1) doneCycle = k;
        else if (doneCount == 2) doneCycle2 = k;
      end
      if (memWe) begin
        memWeCount++;
        if (memWeFirst == 0) memWeFirst = k;
        memWeLast = k;
      end
      if (memRe) begin
        memReCount++;
        if (memReFirst == 0) memReFirst = k;
      end
      if (rfWe) begin
        rfWeCount++;
        if (rfWeFirst == 0) rfWeFirst = k;
        rfWeLast = k;
      end
      if (err) begin
        errCount++;
        if (errCycle == 0) errCycle = k;
      end
      if (memWe && (memRe || rfWe)) overlapCount++;
      if (m != 2'b00 && (memWe || memRe) && memAddr[6:5] != b) addrViolCount++;
      if (resetAt != 0 && k > resetAt && (busy || done || memWe || memRe || rfWe)) postResetCount++;
      @(posedge clock); #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    vectorCount = 0;
    miscompareCount = 0;
    reset = 1'b1; start = 1'b0; mode = 2'b00; blk = 2'b00;
    tbRfWe = 1'b0; tbRfSel = '0; tbRfData = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_busy",   32'(busy),   32'd0);
    checkOutput("reset_done",   32'(done),   32'd0);
    checkOutput("reset_err",    32'(err),    32'd0);
    checkOutput("reset_strobe", 32'({memWe, memRe, rfWe}), 32'd0);
    checkOutput("reset_addr",   32'(memAddr), 32'd0);
    checkOutput("reset_wdata",  memWdata,    32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    $display("[TB] FILL");
    applyStimulus(2'b00, 2'b00, 131, 0, 0, 1'b0);
    checkOutput("fill_we_count", memWeCount, 128);
    checkOutput("fill_we_first", memWeFirst, 1);
    checkOutput("fill_we_last",  memWeLast, 128);
    checkOutput("fill_done_cyc", doneCycle, 129);
    checkOutput("fill_done_cnt", doneCount, 1);
    checkOutput("fill_busy_cnt", busyCount, 129);
    checkOutput("fill_overlap",  overlapCount, 0);
    checkOutput("fill_mem0",     memArray[0],   32'd127);
    checkOutput("fill_mem64",    memArray[64],  32'd63);
    checkOutput("fill_mem127",   memArray[127], 32'd0);

    $display("[TB] LOAD blk=2");
    applyStimulus(2'b01, 2'b10, 36, 0, 0, 1'b0);
    checkOutput("load_rf0",       rfArray[0],  32'd63);
    checkOutput("load_rf31",      rfArray[31], 32'd32);
    checkOutput("load_we_first",  rfWeFirst, 2);
    checkOutput("load_we_last",   rfWeLast, 33);
    checkOutput("load_we_count",  rfWeCount, 32);
    checkOutput("load_re_count",  memReCount, 32);
    checkOutput("load_re_first",  memReFirst, 1);
    checkOutput("load_done_cyc",  doneCycle, 34);
    checkOutput("load_mem_we",    memWeCount, 0);
    checkOutput("load_addr_viol", addrViolCount, 0);

    for (int i = 0; i < 32; i++) begin
      tbRfWe = 1'b1;
      tbRfSel = 5'(i);
      tbRfData = 32'hA5A5_0000 + 32'(i);
      @(posedge clock); #1;
    end
    tbRfWe = 1'b0;

    $display("[TB] STORE blk=3");
    applyStimulus(2'b10, 2'b11, 35, 0, 0, 1'b0);
    checkOutput("store_mem96",    memArray[96],  32'hA5A5_0000);
    checkOutput("store_mem127",   memArray[127], 32'hA5A5_001F);
    checkOutput("store_we_count", memWeCount, 32);
    checkOutput("store_we_first", memWeFirst, 1);
    checkOutput("store_done_cyc", doneCycle, 33);
    checkOutput("store_overlap",  overlapCount, 0);
    checkOutput("store_addr_viol", addrViolCount, 0);
    badCount = 0;
    for (int i = 0; i < 96; i++) begin
      if (memArray[i] !== 32'(127 - i)) badCount++;
    end
    checkOutput("store_mem_kept", badCount, 0);

    $display("[TB] illegal mode");
    applyStimulus(2'b11, 2'b00, 4, 0, 0, 1'b0);
    checkOutput("illegal_err_cnt", errCount, 1);
    checkOutput("illegal_err_cyc", errCycle, 1);
    checkOutput("illegal_busy",    busyCount, 0);
    checkOutput("illegal_strobes", memWeCount + memReCount + rfWeCount, 0);
    checkOutput("illegal_done",    doneCount, 0);

    $display("[TB] LOAD blk=1 with start re-pulse");
    applyStimulus(2'b01, 2'b01, 40, 5, 0, 1'b0);
    checkOutput("repulse_we_count", rfWeCount, 32);
    checkOutput("repulse_done_cnt", doneCount, 1);
    checkOutput("repulse_done_cyc", doneCycle, 34);
    checkOutput("repulse_rf0",      rfArray[0],  32'd95);
    checkOutput("repulse_rf31",     rfArray[31], 32'd64);

    $display("[TB] LOAD blk=2 aborted by reset");
    applyStimulus(2'b01, 2'b10, 30, 0, 12, 1'b0);
    checkOutput("abort_done_cnt",   doneCount, 0);
    checkOutput("abort_post_reset", postResetCount, 0);
    checkOutput("abort_we_count",   rfWeCount, 11);
    checkOutput("abort_rf0",        rfArray[0],  32'd63);
    checkOutput("abort_rf9",        rfArray[9],  32'd54);
    checkOutput("abort_rf20",       rfArray[20], 32'd75);

    $display("[TB] back-to-back LOAD blk=0");
    applyStimulus(2'b01, 2'b00, 69, 0, 0, 1'b1);
    checkOutput("b2b_done_cnt",  doneCount, 2);
    checkOutput("b2b_done_cyc1", doneCycle, 34);
    checkOutput("b2b_done_cyc2", doneCycle2, 69);
    checkOutput("b2b_busy_low",  busyLowCount, 1);
    checkOutput("b2b_we_count",  rfWeCount, 64);
    checkOutput("b2b_rf5",       rfArray[5], 32'd122);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
